// File: rtl/accu_fsm_top.sv
// rtl/accu_fsm_top.sv - button-stepped accumulator with synchronized, edge-detected step input
// Each press of next advances a five-state load/add/sub/hold sequence applied to acc.
module accu_fsm_top #(
  parameter int WIDTH   = 8,
  parameter int SYNC_FF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       state_display
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [SYNC_FF-1:0] sync;
  logic               prev;
  logic               step;

  // Flops reset high so a button held through reset release does not count as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_FF-2:0], next};
      prev <= sync[SYNC_FF-1];
    end
  end

  assign step = sync[SYNC_FF-1] & ~prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      IDLE: if (step) begin state_nxt = LOAD; acc_nxt = in;       end
      LOAD: if (step) begin state_nxt = ADD;  acc_nxt = acc + in; end
      ADD:  if (step) begin state_nxt = SUB;  acc_nxt = acc - in; end
      SUB:  if (step) begin state_nxt = DONE;                     end
      DONE: if (step) begin state_nxt = LOAD; acc_nxt = in;       end
      // Codes 5..7 are unreachable; recover to a clean start.
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
      end
    endcase
  end

  assign out           = acc;
  assign state_display = {1'b0, state};

endmodule

// File: tb/tb_accu_fsm_top.sv
// tb/tb_accu_fsm_top.sv - randomized and directed check of accu_fsm_top against an arithmetic model
module tb_accu_fsm_top;

  logic       clk;
  logic       reset;
  logic       next;
  logic [7:0] in;
  logic [7:0] out;
  logic [3:0] state_display;

  int errors = 0;
  int checks = 0;

  int m_state;
  int m_acc;

  accu_fsm_top #(.WIDTH(8), .SYNC_FF(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .next          (next),
    .in            (in),
    .out           (out),
    .state_display (state_display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_state"}, {4'h0, state_display}, 8'(m_state));
    chk({tag, "_out"}, out, 8'(m_acc));
  endtask

  // Reference: sequence of operations load, add, sub, hold, then reload forever.
  task automatic model_step(input int v);
    case (m_state)
      0: begin m_acc = v;                       m_state = 1; end
      1: begin m_acc = (m_acc + v) % 256;       m_state = 2; end
      2: begin m_acc = (m_acc - v + 256) % 256; m_state = 3; end
      3: begin                                  m_state = 4; end
      default: begin m_acc = v;                 m_state = 1; end
    endcase
  endtask

  task automatic press(input logic [7:0] v);
    @(negedge clk);
    in   = v;
    next = 1'b1;
    repeat (4) @(negedge clk);
    next = 1'b0;
    repeat (3) @(negedge clk);
    model_step(int'(v));
  endtask

  initial begin
    next    = 1'b0;
    in      = 8'h00;
    reset   = 1'b0;
    m_state = 0;
    m_acc   = 0;
    #100;
    chk("in_reset_state", {4'h0, state_display}, 8'h00);
    chk("in_reset_out", out, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_model("after_reset");

    press(8'h05); chk("load_out", out, 8'h05); chk_model("load");
    press(8'h03); chk("add_out", out, 8'h08); chk_model("add");
    press(8'h02); chk("sub_out", out, 8'h06); chk_model("sub");
    press(8'hFF); chk("done_out", out, 8'h06); chk_model("done");
    press(8'hF0); chk("wrap_load", out, 8'hF0); chk_model("wrap_load");
    press(8'h20); chk("overflow", out, 8'h10); chk_model("overflow");
    press(8'h30); chk("underflow", out, 8'hE0); chk_model("underflow");

    // Held button: one advance only.
    @(negedge clk);
    in   = 8'h11;
    next = 1'b1;
    repeat (50) @(negedge clk);
    next = 1'b0;
    repeat (3) @(negedge clk);
    model_step(32'h11);
    chk_model("hold_once");

    // Switch activity without a press leaves everything alone.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    chk_model("toggle_no_press");

    for (int i = 0; i < 20; i++) begin
      press(8'($urandom));
      chk_model("random");
    end

    for (int i = 0; i < 5 && m_state != 2; i++) press(8'($urandom));
    chk("reach_add", {4'h0, state_display}, 8'h02);

    // Async reset between edges, next held across release.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_state", {4'h0, state_display}, 8'h00);
    m_state = 0;
    m_acc   = 0;
    next = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk_model("held_through_release");
    next = 1'b0;
    repeat (5) @(negedge clk);
    chk_model("released_no_step");
    press(8'h42);
    chk("repress_out", out, 8'h42);
    chk_model("repress");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
